// File: rtl/transpose_row_loader.sv
// -----------------------------------------------------------------------------
// transpose_row_loader
//
// Upstream feeder for the transpose FIFO in the systolic matmul datapath.
// Packs a serial valid/ready stream of BITS-wide words into a DEPTH-word
// staging row. It then issues a one-cycle parallel-load strobe to the FIFO and
// drives the FIFO shift enable for exactly DEPTH un-stalled cycles. The next
// row is accepted while the previous one drains.
//
// The first accepted word lands in the highest slot (DEPTH-1), because the
// FIFO emits that index first. A word flagged with in_last closes a short row:
// the remaining lower slots are zeroed and the row is issued as if it were full.
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   rst       in   asynchronous active-high reset
//   in_valid  in   upstream word valid
//   in_data   in   upstream word [BITS-1:0]
//   in_last   in   final word of a short row (sampled on acceptance only)
//   in_ready  out  loader can accept a word
//   stall     in   downstream hold, suppresses shift_en
//   row       out  staging row [DEPTH-1:0] of BITS-wide words -> FIFO parallel in
//   wr_en     out  FIFO parallel-load strobe
//   shift_en  out  FIFO shift enable
//   busy      out  a row is filling or draining
//   done      out  one-cycle pulse after the final shift of a row
// -----------------------------------------------------------------------------
module transpose_row_loader #(
   parameter int DEPTH = 8,
   parameter int BITS  = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [BITS-1:0] in_data,
   input  logic            in_last,
   output logic            in_ready,
   input  logic            stall,
   output logic [BITS-1:0] row [DEPTH-1:0],
   output logic            wr_en,
   output logic            shift_en,
   output logic            busy,
   output logic            done
);

   localparam int             CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]  LAST_C  = CW'(DEPTH - 1);
   localparam logic [CW-1:0]  ONE_C   = CW'(1);
   localparam logic [CW-1:0]  ZERO_C  = CW'(0);

   logic [CW-1:0]   fill_cnt_r;
   logic [CW-1:0]   drain_cnt_r;
   logic [BITS-1:0] staging_r [DEPTH-1:0];
   logic            done_r;

   logic            in_ready_s;
   logic            accept_s;
   logic            wr_en_s;
   logic            shift_en_s;
   logic [CW-1:0]   slot_s;

   // Handshake, issue and drain decodes, all derived from the registered counters.
   always_comb begin
      in_ready_s = (fill_cnt_r < DEPTH_C);
      accept_s   = in_valid & in_ready_s;
      // wr_en needs an empty drain counter, shift_en a non-empty one, so they
      // are mutually exclusive by construction.
      wr_en_s    = (fill_cnt_r == DEPTH_C) & (drain_cnt_r == ZERO_C);
      shift_en_s = (drain_cnt_r != ZERO_C) & ~stall;
      // Destination slot of the next accepted word; only used while filling.
      if (fill_cnt_r < DEPTH_C) begin
         slot_s = LAST_C - fill_cnt_r;
      end else begin
         slot_s = ZERO_C;
      end
   end

   // Fill counter: counts accepted words, jumps to full on in_last, clears on issue.
   // Acceptance and issue never coincide because in_ready is low while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_cnt_r <= ZERO_C;
      end else if (accept_s) begin
         if (in_last) begin
            fill_cnt_r <= DEPTH_C;
         end else begin
            fill_cnt_r <= fill_cnt_r + ONE_C;
         end
      end else if (wr_en_s) begin
         fill_cnt_r <= ZERO_C;
      end
   end

   // Staging row: write the accepted word into its slot; on a short row also
   // zero every lower slot so the FIFO receives a clean, padded row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            staging_r[i] <= '0;
         end
      end else if (accept_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(slot_s)) begin
               staging_r[i] <= in_data;
            end else if (in_last && (i < int'(slot_s))) begin
               staging_r[i] <= '0;
            end
         end
      end
   end

   // Drain counter: loaded with DEPTH on issue, decremented on each shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt_r <= ZERO_C;
      end else if (wr_en_s) begin
         drain_cnt_r <= DEPTH_C;
      end else if (shift_en_s) begin
         drain_cnt_r <= drain_cnt_r - ONE_C;
      end
   end

   // Done pulse: registered in the cycle after the final shift of a row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_r <= 1'b0;
      end else begin
         done_r <= shift_en_s & (drain_cnt_r == ONE_C);
      end
   end

   assign in_ready = in_ready_s;
   assign wr_en    = wr_en_s;
   assign shift_en = shift_en_s;
   assign busy     = (fill_cnt_r != ZERO_C) | (drain_cnt_r != ZERO_C);
   assign done     = done_r;
   assign row      = staging_r;

endmodule

// File: tb/tb_transpose_row_loader.sv
// -----------------------------------------------------------------------------
// tb_transpose_row_loader
//
// Self-checking bench for transpose_row_loader (DEPTH=8, BITS=64).
// A cycle table covers back-to-back fill, issue, overlapped fill during drain
// and a stalled drain. Hand-written sequences cover reset with in_valid high,
// a short row and reset in the middle of a drain.
// -----------------------------------------------------------------------------
module tb_transpose_row_loader;

   localparam int DEPTH = 8;
   localparam int BITS  = 64;
   localparam int NVEC  = 31;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic [BITS-1:0] in_data;
   logic            in_last;
   logic            in_ready;
   logic            stall;
   logic [BITS-1:0] row [DEPTH-1:0];
   logic            wr_en;
   logic            shift_en;
   logic            busy;
   logic            done;

   int errors = 0;
   int checks = 0;

   transpose_row_loader #(.DEPTH(DEPTH), .BITS(BITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_ready (in_ready),
      .stall    (stall),
      .row      (row),
      .wr_en    (wr_en),
      .shift_en (shift_en),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            v;
      logic [BITS-1:0] d;
      logic            l;
      logic            s;
      logic            e_rdy;
      logic            e_wr;
      logic            e_sh;
      logic            e_busy;
      logic            e_done;
      logic            chk_row;
      logic [BITS-1:0] row_base;
   } vec_t;

   vec_t tbl [NVEC];

   task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [BITS-1:0] d, input logic l, input logic s);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      stall    = s;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic rdy, input logic wr,
                                input logic sh, input logic bsy, input logic dn);
      check({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
      check({tag, ".wr_en"},    {63'd0, wr_en},    {63'd0, wr});
      check({tag, ".shift_en"}, {63'd0, shift_en}, {63'd0, sh});
      check({tag, ".busy"},     {63'd0, busy},     {63'd0, bsy});
      check({tag, ".done"},     {63'd0, done},     {63'd0, dn});
   endtask

   // Checks row[7]=base, row[6]=base+1, ... row[0]=base+7.
   task automatic check_row_seq(input string tag, input logic [BITS-1:0] base);
      for (int j = 0; j < DEPTH; j++) begin
         check($sformatf("%s.row[%0d]", tag, DEPTH-1-j), row[DEPTH-1-j], base + 64'(j));
      end
   endtask

   task automatic set_vec(input int i, input logic v, input logic [BITS-1:0] d, input logic s,
                          input logic rdy, input logic wr, input logic sh, input logic bsy,
                          input logic dn, input logic cr, input logic [BITS-1:0] rb);
      tbl[i] = '{v, d, 1'b0, s, rdy, wr, sh, bsy, dn, cr, rb};
   endtask

   initial begin
      int shifts;
      int dones;
      int done_at_shift;

      // Table: starts from an empty loader right after reset release.
      for (int k = 0; k < 8; k++) begin
         set_vec(k, 1'b1, 64'h10 + 64'(k), 1'b0, 1'b1, 1'b0, 1'b0, (k != 0), 1'b0, 1'b0, 64'h0);
      end
      set_vec(8, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h10);
      // Second row filled while the first drains.
      for (int k = 0; k < 8; k++) begin
         set_vec(9 + k, 1'b1, 64'h20 + 64'(k), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      end
      // Second issue coincides with the first done.
      set_vec(17, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h20);
      for (int k = 0; k < 4; k++) begin
         set_vec(18 + k, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      end
      // Three stalled cycles after the fourth shift.
      for (int k = 0; k < 3; k++) begin
         set_vec(22 + k, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
      end
      for (int k = 0; k < 4; k++) begin
         set_vec(25 + k, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      end
      set_vec(29, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
      set_vec(30, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

      // Reset held with in_valid high: outputs idle, nothing captured.
      rst = 1'b1;
      drive(1'b1, 64'hFF, 1'b0, 1'b0);
      @(negedge clk);
      check_outputs("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < DEPTH; j++) begin
         check($sformatf("rst0.row[%0d]", j), row[j], 64'h0);
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_outputs("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // Table-driven run: full row, overlap, stall.
      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s);
         @(negedge clk);
         check_outputs($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_wr,
                       tbl[i].e_sh, tbl[i].e_busy, tbl[i].e_done);
         if (tbl[i].chk_row) begin
            check_row_seq($sformatf("v%0d", i), tbl[i].row_base);
         end
         next_cycle();
      end

      // Short row: A, B, then C with in_last. Lower slots still hold row 0x20.. data.
      drive(1'b1, 64'hA, 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 64'hB, 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 64'hC, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      @(negedge clk);
      check_outputs("short_issue", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("short.row[7]", row[7], 64'hA);
      check("short.row[6]", row[6], 64'hB);
      check("short.row[5]", row[5], 64'hC);
      for (int j = 0; j < 5; j++) begin
         check($sformatf("short.row[%0d]", j), row[j], 64'h0);
      end
      next_cycle();
      shifts = 0;
      dones = 0;
      done_at_shift = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            done_at_shift = shifts;
         end
         if (shift_en) shifts++;
         next_cycle();
      end
      check("short.shift_count", 64'(shifts), 64'd8);
      check("short.done_count", 64'(dones), 64'd1);
      check("short.done_after_shift", 64'(done_at_shift), 64'd8);
      @(negedge clk);
      check("short.busy_end", {63'd0, busy}, 64'd0);
      next_cycle();

      // Reset mid-drain: row 0x40.., four shifts, then asynchronous reset.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 64'h40 + 64'(k), 1'b0, 1'b0);
         next_cycle();
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      @(negedge clk);
      check("mid.wr_en", {63'd0, wr_en}, 64'd1);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("mid.shift%0d", k), {63'd0, shift_en}, 64'd1);
         next_cycle();
      end
      rst = 1'b1;
      #1;
      check_outputs("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < DEPTH; j++) begin
         check($sformatf("mid_rst.row[%0d]", j), row[j], 64'h0);
      end
      next_cycle();
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done || shift_en) dones++;
         next_cycle();
      end
      check("mid.no_done_or_shift", 64'(dones), 64'd0);

      // Fresh row after reset must start at slot 7.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 64'h30 + 64'(k), 1'b0, 1'b0);
         next_cycle();
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      @(negedge clk);
      check_outputs("post_rst_issue", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_row_seq("post_rst", 64'h30);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
